// File: rtl/replay_fifo.sv
// replay_fifo: parametrised FIFO that keeps read entries until they are
// acknowledged, so a lossy consumer can rewind and re-read them.
// Three pointers (write, read, ack) carry one extra MSB so that the
// full and empty states can be told apart, and they wrap naturally.
module replay_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              ack,
  input  logic              replay,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0] PtrOne   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DepthVal = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ack_ptr_q, ack_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic wrAcc;
  logic rdReq;
  logic rdAcc;
  logic rdRej;
  logic ackAcc;
  logic ackRej;
  logic replayReq;

  // Status flags come only from the registered pointers, so every accept
  // decision below sees the state as it was at the start of the cycle.
  assign level = wr_ptr_q - ack_ptr_q;
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (level == DepthVal);

  // A replay takes priority over a read in the same cycle and silences it
  // entirely (no data, no underflow).
  assign replayReq = en & replay;
  assign wrAcc     = en & wr & ~full;
  assign rdReq     = en & rd & ~replay;
  assign rdAcc     = rdReq & ~empty;
  assign rdRej     = rdReq & empty;
  assign ackAcc    = en & ack & (rd_ptr_q != ack_ptr_q);
  assign ackRej    = en & ack & (rd_ptr_q == ack_ptr_q);

  // Next-state logic for pointers, read data and the one-cycle status pulses.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ack_ptr_d  = ack_ptr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ovf_d      = en & wr & full;
    udf_d      = rdRej | ackRej;

    if (wrAcc) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end

    if (ackAcc) begin
      ack_ptr_d = ack_ptr_q + PtrOne;
    end

    // Replay rewinds to the oldest unacked entry, including any ack taken
    // in this same cycle.
    if (replayReq) begin
      rd_ptr_d = ack_ptr_d;
    end else if (rdAcc) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      data_out_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      valid_d    = 1'b1;
    end
  end

  // Pointer and output registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ack_ptr_q  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ack_ptr_q  <= ack_ptr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array; contents survive reset and are only overwritten by writes.
  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_replay_fifo.sv
// Testbench for replay_fifo (DATA_W=16, DEPTH=4): table of directed vectors
// with hand-computed expectations plus a few hand-written sequences.
module tb_replay_fifo;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] din;
    logic        rd;
    logic        ack;
    logic        rep;
    logic        expValid;
    logic [15:0] expData;
    logic        expEmpty;
    logic        expFull;
    logic [2:0]  expLevel;
    logic        expOvf;
    logic        expUdf;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        en;
  logic        wr;
  logic [15:0] dataIn;
  logic        rd;
  logic        ack;
  logic        replay;
  logic [15:0] dataOut;
  logic        valid;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic        ovf;
  logic        udf;

  int checks = 0;
  int errors = 0;

  vec_t vecs[30];

  replay_fifo #(.DATA_W(16), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .en       (en),
    .wr       (wr),
    .data_in  (dataIn),
    .rd       (rd),
    .ack      (ack),
    .replay   (replay),
    .data_out (dataOut),
    .valid    (valid),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .ovf      (ovf),
    .udf      (udf)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic w, input logic [15:0] d,
                              input logic r, input logic a, input logic p,
                              input logic xv, input logic [15:0] xd,
                              input logic xe, input logic xf, input logic [2:0] xl,
                              input logic xo, input logic xu);
    vec_t v;
    v.en = e; v.wr = w; v.din = d; v.rd = r; v.ack = a; v.rep = p;
    v.expValid = xv; v.expData = xd; v.expEmpty = xe; v.expFull = xf;
    v.expLevel = xl; v.expOvf = xo; v.expUdf = xu;
    return v;
  endfunction

  task automatic checkField(input string name, input int idx,
                            input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkField("valid", idx, {15'd0, valid}, {15'd0, v.expValid});
    checkField("data_out", idx, dataOut, v.expData);
    checkField("empty", idx, {15'd0, empty}, {15'd0, v.expEmpty});
    checkField("full", idx, {15'd0, full}, {15'd0, v.expFull});
    checkField("level", idx, {13'd0, level}, {13'd0, v.expLevel});
    checkField("ovf", idx, {15'd0, ovf}, {15'd0, v.expOvf});
    checkField("udf", idx, {15'd0, udf}, {15'd0, v.expUdf});
  endtask

  // Drive one cycle of inputs on the falling edge, then check just after
  // the following rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    en = v.en; wr = v.wr; dataIn = v.din; rd = v.rd; ack = v.ack; replay = v.rep;
    @(posedge clk);
    #1;
    checkOutput(v, idx);
  endtask

  initial begin
    //                    en wr din      rd ack rep | v  data     e  f  lvl ovf udf
    vecs[0]  = mk(1, 1, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 0, 3'd1, 0, 0);
    vecs[1]  = mk(1, 1, 16'h0001, 0, 0, 0,  0, 16'h0000, 0, 0, 3'd2, 0, 0);
    vecs[2]  = mk(1, 1, 16'h0002, 0, 0, 0,  0, 16'h0000, 0, 0, 3'd3, 0, 0);
    vecs[3]  = mk(1, 1, 16'h0003, 0, 0, 0,  0, 16'h0000, 0, 1, 3'd4, 0, 0);
    vecs[4]  = mk(1, 1, 16'h0004, 0, 0, 0,  0, 16'h0000, 0, 1, 3'd4, 1, 0);
    vecs[5]  = mk(1, 0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 1, 3'd4, 0, 0);
    vecs[6]  = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0000, 0, 1, 3'd4, 0, 0);
    vecs[7]  = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0001, 0, 1, 3'd4, 0, 0);
    vecs[8]  = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0002, 0, 1, 3'd4, 0, 0);
    vecs[9]  = mk(1, 0, 16'h0000, 0, 0, 1,  0, 16'h0002, 0, 1, 3'd4, 0, 0);
    vecs[10] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0000, 0, 1, 3'd4, 0, 0);
    vecs[11] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0001, 0, 1, 3'd4, 0, 0);
    vecs[12] = mk(1, 0, 16'h0000, 0, 1, 0,  0, 16'h0001, 0, 0, 3'd3, 0, 0);
    vecs[13] = mk(1, 0, 16'h0000, 0, 1, 0,  0, 16'h0001, 0, 0, 3'd2, 0, 0);
    vecs[14] = mk(1, 1, 16'h0004, 0, 0, 0,  0, 16'h0001, 0, 0, 3'd3, 0, 0);
    vecs[15] = mk(1, 0, 16'h0000, 0, 0, 1,  0, 16'h0001, 0, 0, 3'd3, 0, 0);
    vecs[16] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0002, 0, 0, 3'd3, 0, 0);
    vecs[17] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0003, 0, 0, 3'd3, 0, 0);
    vecs[18] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0004, 1, 0, 3'd3, 0, 0);
    vecs[19] = mk(1, 0, 16'h0000, 1, 0, 0,  0, 16'h0004, 1, 0, 3'd3, 0, 1);
    vecs[20] = mk(1, 0, 16'h0000, 0, 1, 0,  0, 16'h0004, 1, 0, 3'd2, 0, 0);
    vecs[21] = mk(1, 0, 16'h0000, 0, 1, 0,  0, 16'h0004, 1, 0, 3'd1, 0, 0);
    vecs[22] = mk(1, 0, 16'h0000, 0, 1, 0,  0, 16'h0004, 1, 0, 3'd0, 0, 0);
    vecs[23] = mk(1, 0, 16'h0000, 0, 1, 0,  0, 16'h0004, 1, 0, 3'd0, 0, 1);
    vecs[24] = mk(0, 1, 16'h0055, 1, 1, 1,  0, 16'h0004, 1, 0, 3'd0, 0, 0);
    vecs[25] = mk(1, 1, 16'h0077, 1, 0, 0,  0, 16'h0004, 0, 0, 3'd1, 0, 1);
    vecs[26] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0077, 1, 0, 3'd1, 0, 0);
    vecs[27] = mk(1, 0, 16'h0000, 1, 0, 1,  0, 16'h0077, 0, 0, 3'd1, 0, 0);
    vecs[28] = mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h0077, 1, 0, 3'd1, 0, 0);
    vecs[29] = mk(1, 0, 16'h0000, 0, 1, 1,  0, 16'h0077, 1, 0, 3'd0, 0, 0);

    rstN = 1'b0; en = 1'b0; wr = 1'b0; dataIn = '0; rd = 1'b0; ack = 1'b0; replay = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput(mk(0, 0, 0, 0, 0, 0,  0, 16'h0000, 1, 0, 3'd0, 0, 0), 900);
    rstN = 1'b1;

    // Reset asserted in the middle of traffic must clear everything at once.
    applyStimulus(mk(1, 1, 16'h0011, 0, 0, 0,  0, 16'h0000, 0, 0, 3'd1, 0, 0), 901);
    applyStimulus(mk(1, 1, 16'h0022, 0, 0, 0,  0, 16'h0000, 0, 0, 3'd2, 0, 0), 902);
    applyStimulus(mk(1, 1, 16'h0033, 1, 0, 0,  1, 16'h0011, 0, 0, 3'd3, 0, 0), 903);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput(mk(0, 0, 0, 0, 0, 0,  0, 16'h0000, 1, 0, 3'd0, 0, 0), 904);
    @(negedge clk);
    en = 1'b0; wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    checkOutput(mk(0, 0, 0, 0, 0, 0,  0, 16'h0000, 1, 0, 3'd0, 0, 0), 905);
    rstN = 1'b1;

    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Write on a full FIFO together with an ack: write rejected, ack taken.
    applyStimulus(mk(1, 1, 16'h00A0, 0, 0, 0,  0, 16'h0077, 0, 0, 3'd1, 0, 0), 950);
    applyStimulus(mk(1, 1, 16'h00A1, 0, 0, 0,  0, 16'h0077, 0, 0, 3'd2, 0, 0), 951);
    applyStimulus(mk(1, 1, 16'h00A2, 0, 0, 0,  0, 16'h0077, 0, 0, 3'd3, 0, 0), 952);
    applyStimulus(mk(1, 1, 16'h00A3, 0, 0, 0,  0, 16'h0077, 0, 1, 3'd4, 0, 0), 953);
    applyStimulus(mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00A0, 0, 1, 3'd4, 0, 0), 954);
    applyStimulus(mk(1, 1, 16'h00A4, 0, 1, 0,  0, 16'h00A0, 0, 0, 3'd3, 1, 0), 955);
    applyStimulus(mk(1, 1, 16'h00A5, 0, 0, 0,  0, 16'h00A0, 0, 1, 3'd4, 0, 0), 956);
    applyStimulus(mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00A1, 0, 1, 3'd4, 0, 0), 957);
    applyStimulus(mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00A2, 0, 1, 3'd4, 0, 0), 958);
    applyStimulus(mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00A3, 0, 1, 3'd4, 0, 0), 959);
    applyStimulus(mk(1, 0, 16'h0000, 1, 0, 0,  1, 16'h00A5, 1, 1, 3'd4, 0, 0), 960);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
